multi_way_traffic_controller: RTL and testbench

MULTI_WAY_TRAFFIC_CONTROLLER -- requirements
Module: multi_way_traffic_controller

---
 rtl/multi_way_traffic_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multi_way_traffic_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_way_traffic_controller.sv
// multi_way_traffic_controller
// Round-robin signal controller for N_ROADS approaches. Each road gets a green
// that lasts at least GREEN_MIN cycles. The green is extended while the road
// still has demand, but never beyond GREEN_MAX cycles once another road is
// waiting. Every green ends with YELLOW_T cycles of yellow and then ALLRED_T
// cycles of all-red. An emergency request preempts the current green and
// selects the next road directly.
module multi_way_traffic_controller #(
  parameter int N_ROADS   = 4,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8,
  localparam int RW = (N_ROADS > 1) ? $clog2(N_ROADS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_ROADS-1:0]   demand,
  input  logic                 emerg_req,
  input  logic [RW-1:0]        emerg_road,
  output logic [2*N_ROADS-1:0] lights,
  output logic [RW-1:0]        active_road,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    ST_GREEN   = 2'b00,
    ST_YELLOW  = 2'b01,
    ST_ALL_RED = 2'b10
  } state_t;

  // Each phase ends on the cycle in which the timer holds "length - 1".
  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT      = {CNT_W{1'b1}};

  state_t               state_r;
  state_t               state_nxt;
  logic [CNT_W-1:0]     timer_r;
  logic [CNT_W-1:0]     timer_nxt;
  logic [N_ROADS-1:0]   pending_r;
  logic [N_ROADS-1:0]   pending_nxt;
  logic [RW-1:0]        active_r;
  logic [RW-1:0]        active_nxt;
  logic [2*N_ROADS-1:0] lights_r;

  logic [RW-1:0]        emerg_tgt;
  logic [RW-1:0]        scan_road;
  logic                 scan_found;

  // Light pattern for a given phase and owning road. Only the owner is lit.
  function automatic logic [2*N_ROADS-1:0] decode_lights(input state_t st,
                                                         input logic [RW-1:0] road);
    logic [2*N_ROADS-1:0] l;
    l = '0;
    for (int i = 0; i < N_ROADS; i++) begin
      if (RW'(i) == road) begin
        case (st)
          ST_GREEN:  l[2*i +: 2] = 2'b10;
          ST_YELLOW: l[2*i +: 2] = 2'b01;
          default:   l[2*i +: 2] = 2'b00;
        endcase
      end else begin
        l[2*i +: 2] = 2'b00;
      end
    end
    return l;
  endfunction

  // Map an out-of-range emergency target onto road 0.
  always_comb begin
    if (int'(emerg_road) < N_ROADS) begin
      emerg_tgt = emerg_road;
    end else begin
      emerg_tgt = '0;
    end
  end

  // Round-robin search for the first pending road after the active one.
  // If any road is found, it also means another road is waiting.
  always_comb begin
    int idx;
    idx        = 0;
    scan_found = 1'b0;
    scan_road  = active_r;
    for (int k = 1; k < N_ROADS; k++) begin
      idx = int'(active_r) + k;
      if (idx >= N_ROADS) begin
        idx = idx - N_ROADS;
      end else begin
        idx = idx;
      end
      if (!scan_found && pending_r[idx]) begin
        scan_found = 1'b1;
        scan_road  = RW'(idx);
      end else begin
        scan_found = scan_found;
      end
    end
  end

  // Next-state logic: demand capture, phase sequencing, road selection and timer.
  always_comb begin
    state_nxt   = state_r;
    active_nxt  = active_r;
    pending_nxt = pending_r;
    timer_nxt   = timer_r;

    // Record demand for every road except the one that is currently green.
    for (int i = 0; i < N_ROADS; i++) begin
      if (demand[i] && !(state_r == ST_GREEN && active_r == RW'(i))) begin
        pending_nxt[i] = 1'b1;
      end else begin
        pending_nxt[i] = pending_r[i];
      end
    end

    case (state_r)
      ST_GREEN: begin
        if (emerg_req) begin
          // Preempt immediately if another road is requested, otherwise hold.
          if (emerg_tgt != active_r) begin
            state_nxt = ST_YELLOW;
          end else begin
            state_nxt = ST_GREEN;
          end
        end else if (timer_r >= GREEN_MIN_LAST && scan_found &&
                     (!demand[active_r] || timer_r >= GREEN_MAX_LAST)) begin
          state_nxt = ST_YELLOW;
        end else begin
          state_nxt = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (timer_r >= YELLOW_LAST) begin
          state_nxt = ST_ALL_RED;
        end else begin
          state_nxt = ST_YELLOW;
        end
      end
      ST_ALL_RED: begin
        if (timer_r >= ALLRED_LAST) begin
          state_nxt = ST_GREEN;
          // The emergency target is sampled on the cycle the clearance ends.
          if (emerg_req) begin
            active_nxt = emerg_tgt;
          end else if (scan_found) begin
            active_nxt = scan_road;
          end else begin
            active_nxt = active_r;
          end
          // Entering green clears that road's request. This clear overrides a
          // set from the same cycle.
          pending_nxt[active_nxt] = 1'b0;
        end else begin
          state_nxt = ST_ALL_RED;
        end
      end
      default: begin
        state_nxt  = ST_GREEN;
        active_nxt = '0;
      end
    endcase

    // The timer restarts at 0 in every new phase and saturates instead of wrapping.
    if (state_nxt != state_r) begin
      timer_nxt = '0;
    end else if (timer_r != TIMER_SAT) begin
      timer_nxt = timer_r + CNT_W'(1);
    end else begin
      timer_nxt = timer_r;
    end
  end

  // State registers with synchronous active-low reset. Lights are registered
  // from the next state so that they always match phase and active_road.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_GREEN;
      timer_r   <= '0;
      pending_r <= '0;
      active_r  <= '0;
      lights_r  <= decode_lights(ST_GREEN, '0);
    end else begin
      state_r   <= state_nxt;
      timer_r   <= timer_nxt;
      pending_r <= pending_nxt;
      active_r  <= active_nxt;
      lights_r  <= decode_lights(state_nxt, active_nxt);
    end
  end

  assign lights      = lights_r;
  assign active_road = active_r;
  assign phase       = state_r;

endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// Testbench for multi_way_traffic_controller with 3 roads, GREEN_MIN=4,
// GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1 and a 4-bit timer (so the timer saturates).
// Every cycle is compared against a phase/age reference model. The bench also
// applies a table of hand-derived vectors and several directed sequences.
module tb_multi_way_traffic_controller;

  localparam int N         = 3;
  localparam int GREEN_MIN = 4;
  localparam int GREEN_MAX = 8;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int CNT_W     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] demand;
  logic       emerg_req;
  logic [1:0] emerg_road;
  logic [5:0] lights;
  logic [1:0] active_road;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference model. Phase is 0 green, 1 yellow or 2 all-red. Age counts the
  // cycles spent in the current phase, including the present cycle.
  int     m_phase;
  int     m_age;
  int     m_road;
  bit [2:0] m_pend;

  typedef struct {
    logic       rst;
    logic [2:0] dem;
    logic       er;
    logic [1:0] eroad;
    logic [5:0] exp_lights;
    logic [1:0] exp_phase;
    logic [1:0] exp_active;
  } vec_t;

  vec_t vecs[18];

  int         bad;
  int         gcount;
  int         seq[$];
  int         last_road;
  bit         found;
  logic       r_er;
  logic [1:0] r_eroad;
  logic [2:0] r_dem;
  logic       r_rst;

  multi_way_traffic_controller #(
    .N_ROADS(N), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .demand(demand), .emerg_req(emerg_req),
    .emerg_road(emerg_road), .lights(lights), .active_road(active_road), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_lights(input int ph, input int road);
    logic [5:0] l;
    l = '0;
    if (ph == 0) l[2*road +: 2] = 2'b10;
    else if (ph == 1) l[2*road +: 2] = 2'b01;
    else l = '0;
    return l;
  endfunction

  task automatic model_step(input logic rst, input logic [2:0] dem, input logic er,
                            input logic [1:0] eroad);
    bit [2:0] np;
    int tgt;
    int nxt;
    bit others;
    if (!rst) begin
      m_phase = 0; m_road = 0; m_age = 1; m_pend = '0;
      return;
    end
    np = m_pend;
    for (int i = 0; i < N; i++)
      if (dem[i] && !(m_phase == 0 && m_road == i)) np[i] = 1'b1;
    tgt = (int'(eroad) < N) ? int'(eroad) : 0;
    others = 1'b0;
    nxt = m_road;
    for (int k = N - 1; k >= 1; k--)
      if (m_pend[(m_road + k) % N]) begin others = 1'b1; nxt = (m_road + k) % N; end
    case (m_phase)
      0: begin
        if ((er && tgt != m_road) ||
            (!er && m_age >= GREEN_MIN && others && (!dem[m_road] || m_age >= GREEN_MAX))) begin
          m_phase = 1; m_age = 1;
        end else m_age++;
      end
      1: begin
        if (m_age >= YELLOW_T) begin m_phase = 2; m_age = 1; end
        else m_age++;
      end
      default: begin
        if (m_age >= ALLRED_T) begin
          m_phase = 0; m_age = 1;
          m_road = er ? tgt : nxt;
          np[m_road] = 1'b0;
        end else m_age++;
      end
    endcase
    m_pend = np;
  endtask

  // Applies one cycle of inputs, advances the model and compares the outputs.
  task automatic tick(input logic rst, input logic [2:0] dem, input logic er,
                      input logic [1:0] eroad, input string nm);
    reset = rst; demand = dem; emerg_req = er; emerg_road = eroad;
    @(posedge clk);
    model_step(rst, dem, er, eroad);
    #1;
    checks++;
    if (lights !== model_lights(m_phase, m_road) || phase !== 2'(m_phase) ||
        active_road !== 2'(m_road)) begin
      errors++;
      $display("FAIL %s: got lights=%b phase=%b active=%0d, model lights=%b phase=%0d active=%0d",
               nm, lights, phase, active_road, model_lights(m_phase, m_road), m_phase, m_road);
    end
  endtask

  task automatic run_until(input logic [1:0] ph, input logic [1:0] road, input int bound,
                           input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      tick(1'b1, 3'b000, 1'b0, 2'b00, nm);
      if (phase == ph && active_road == road) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: phase=%b active=%0d, required phase=%b active=%0d within %0d cycles",
               nm, phase, active_road, ph, road, bound);
    end
  endtask

  initial begin
    reset = 1'b0; demand = '0; emerg_req = 1'b0; emerg_road = '0;

    // rst dem er eroad | lights phase active
    vecs[0]  = '{1'b0, 3'b000, 1'b0, 2'd0, 6'b000010, 2'b00, 2'd0};
    vecs[1]  = '{1'b1, 3'b100, 1'b0, 2'd0, 6'b000010, 2'b00, 2'd0};
    vecs[2]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b000010, 2'b00, 2'd0};
    vecs[3]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b000010, 2'b00, 2'd0};
    vecs[4]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b000001, 2'b01, 2'd0};
    vecs[5]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b000001, 2'b01, 2'd0};
    vecs[6]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b000000, 2'b10, 2'd0};
    vecs[7]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b100000, 2'b00, 2'd2};
    vecs[8]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b100000, 2'b00, 2'd2};
    vecs[9]  = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b100000, 2'b00, 2'd2};
    vecs[10] = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b100000, 2'b00, 2'd2};
    vecs[11] = '{1'b1, 3'b010, 1'b0, 2'd0, 6'b100000, 2'b00, 2'd2};
    vecs[12] = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b010000, 2'b01, 2'd2};
    vecs[13] = '{1'b1, 3'b000, 1'b1, 2'd3, 6'b010000, 2'b01, 2'd2};
    vecs[14] = '{1'b1, 3'b000, 1'b1, 2'd3, 6'b000000, 2'b10, 2'd2};
    vecs[15] = '{1'b1, 3'b000, 1'b1, 2'd3, 6'b000010, 2'b00, 2'd0};
    vecs[16] = '{1'b1, 3'b000, 1'b1, 2'd3, 6'b000010, 2'b00, 2'd0};
    vecs[17] = '{1'b1, 3'b000, 1'b0, 2'd0, 6'b000010, 2'b00, 2'd0};

    for (int v = 0; v < 18; v++) begin
      tick(vecs[v].rst, vecs[v].dem, vecs[v].er, vecs[v].eroad, $sformatf("vec%0d_model", v));
      checks++;
      if (lights !== vecs[v].exp_lights || phase !== vecs[v].exp_phase ||
          active_road !== vecs[v].exp_active) begin
        errors++;
        $display("FAIL vec%0d: got lights=%b phase=%b active=%0d, want lights=%b phase=%b active=%0d",
                 v, lights, phase, active_road, vecs[v].exp_lights, vecs[v].exp_phase,
                 vecs[v].exp_active);
      end
    end

    // With no demand, road 0 rests on green for 50 cycles.
    tick(1'b0, 3'b000, 1'b0, 2'd0, "idle_reset");
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1'b1, 3'b000, 1'b0, 2'd0, "idle");
      if (lights != 6'b000010 || phase != 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_rest: %0d off-green cycles, required 0", bad); end

    // Held demand on road 0 extends its green to exactly GREEN_MAX cycles.
    tick(1'b0, 3'b000, 1'b0, 2'd0, "max_reset");
    gcount = 1;
    tick(1'b1, 3'b011, 1'b0, 2'd0, "max_pulse");
    if (phase == 2'b00 && active_road == 2'd0) gcount++;
    for (int c = 0; c < 30 && phase == 2'b00; c++) begin
      tick(1'b1, 3'b001, 1'b0, 2'd0, "max_hold");
      if (phase == 2'b00 && active_road == 2'd0) gcount++;
    end
    checks++;
    if (gcount != GREEN_MAX || phase != 2'b01) begin
      errors++;
      $display("FAIL green_max: green cycles=%0d phase=%b, required %0d then 01", gcount, phase, GREEN_MAX);
    end
    run_until(2'b00, 2'd1, 10, "max_next_road1");

    // Two simultaneous requests are served in round-robin order, then the controller rests.
    tick(1'b0, 3'b000, 1'b0, 2'd0, "rr_reset");
    tick(1'b1, 3'b110, 1'b0, 2'd0, "rr_pulse");
    seq.delete();
    last_road = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, 3'b000, 1'b0, 2'd0, "rr_run");
      if (phase == 2'b00 && int'(active_road) != last_road) begin
        last_road = int'(active_road);
        seq.push_back(last_road);
      end
    end
    checks++;
    if (seq.size() != 2 || seq[0] != 1 || seq[1] != 2 || active_road != 2'd2 || phase != 2'b00) begin
      errors++;
      $display("FAIL round_robin: served %0d roads, final active=%0d phase=%b, required 1,2 then rest on 2",
               seq.size(), active_road, phase);
    end

    // Emergency preemption at timer=1 of road 0 green.
    tick(1'b0, 3'b000, 1'b0, 2'd0, "em_reset");
    tick(1'b1, 3'b010, 1'b0, 2'd0, "em_demand1");
    tick(1'b1, 3'b000, 1'b1, 2'd2, "em_assert");
    checks++;
    if (phase != 2'b01 || active_road != 2'd0) begin
      errors++;
      $display("FAIL em_yellow: phase=%b active=%0d, required 01 and 0", phase, active_road);
    end
    for (int c = 0; c < 3; c++) tick(1'b1, 3'b000, 1'b1, 2'd2, "em_clear");
    checks++;
    if (lights != 6'b100000 || active_road != 2'd2) begin
      errors++;
      $display("FAIL em_green: lights=%b active=%0d, required 100000 and 2", lights, active_road);
    end
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick(1'b1, 3'b000, 1'b1, 2'd2, "em_hold");
      if (lights != 6'b100000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL em_hold: %0d cycles left road2, required 0", bad); end
    tick(1'b1, 3'b000, 1'b0, 2'd2, "em_release");
    checks++;
    if (phase != 2'b01 || active_road != 2'd2) begin
      errors++;
      $display("FAIL em_release: phase=%b active=%0d, required 01 and 2", phase, active_road);
    end
    run_until(2'b00, 2'd1, 10, "em_pending_kept");

    // Reset taken during the yellow of road 1, with demand present in the reset cycle.
    tick(1'b0, 3'b000, 1'b0, 2'd0, "ry_reset");
    tick(1'b1, 3'b010, 1'b0, 2'd0, "ry_dem1");
    run_until(2'b00, 2'd1, 20, "ry_road1_green");
    tick(1'b1, 3'b100, 1'b0, 2'd0, "ry_dem2");
    run_until(2'b01, 2'd1, 20, "ry_road1_yellow");
    tick(1'b0, 3'b100, 1'b0, 2'd0, "ry_assert");
    checks++;
    if (lights != 6'b000010 || phase != 2'b00 || active_road != 2'd0) begin
      errors++;
      $display("FAIL ry_state: lights=%b phase=%b active=%0d, required 000010 00 0", lights, phase, active_road);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 3'b000, 1'b0, 2'd0, "ry_after");
      if (lights != 6'b000010) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ry_pending_clear: %0d cycles off road0, required 0", bad); end

    // Randomized traffic, emergencies and occasional resets against the model.
    r_er = 1'b0;
    r_eroad = 2'd0;
    tick(1'b0, 3'b000, 1'b0, 2'd0, "rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      if (!r_er && $urandom_range(39, 0) == 0) r_er = 1'b1;
      else if (r_er && $urandom_range(9, 0) == 0) r_er = 1'b0;
      if ($urandom_range(7, 0) == 0) r_eroad = 2'($urandom_range(3, 0));
      for (int i = 0; i < 3; i++) r_dem[i] = ($urandom_range(5, 0) == 0);
      r_rst = ($urandom_range(299, 0) != 0);
      tick(r_rst, r_dem, r_er, r_eroad, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
